// File: rtl/image_dm_loader.sv
// -----------------------------------------------------------------------------
// image_dm_loader
//   Host-side front end for the down-sampling processor. It streams the
//   source image into data memory (DM) while holding the processor in reset,
//   then releases the processor and hands it the DM port. When the processor
//   raises proc_done, the block takes the DM port back, puts the processor
//   back into reset and streams the result image out of DM. The block then
//   raises a sticky done flag.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_data    source pixel byte         in_valid / in_ready handshake
//   out_data   result pixel byte         out_valid / out_ready handshake
//   proc_rst   processor reset (1 = held in reset)
//   proc_done  processor completion flag (level)
//   mem_sel    DM port owner (1 = this block, 0 = processor)
//   dm_addr    DM address, dm_wdata write data, dm_we write enable
//   dm_rdata   DM read data, valid one cycle after dm_addr
//   done       whole result frame delivered (sticky until rst)
//
// All outputs are registered. Address arithmetic is ADDR_W bits wide and
// wraps, so the image ranges must fit in the DM address space.
// -----------------------------------------------------------------------------
module image_dm_loader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int IN_PIXELS  = 65536,
  parameter int OUT_BASE   = 65536,
  parameter int OUT_PIXELS = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              proc_rst,
  input  logic              proc_done,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_RD_ADDR,
    S_RD_WAIT,
    S_RD_OUT,
    S_DONE
  } state_e;

  // Last valid counter values, compared against the counter before it
  // increments so no extra counter bit is needed.
  localparam logic [ADDR_W-1:0] IN_LAST    = ADDR_W'(IN_PIXELS - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST   = ADDR_W'(OUT_PIXELS - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);

  state_e              state_q;
  logic [ADDR_W-1:0]   wr_cnt_q;
  logic [ADDR_W-1:0]   rd_cnt_q;
  logic [ADDR_W-1:0]   wr_cnt_d;
  logic [ADDR_W-1:0]   rd_cnt_d;

  logic                in_ready_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                proc_rst_q;
  logic                mem_sel_q;
  logic [ADDR_W-1:0]   dm_addr_q;
  logic [DATA_W-1:0]   dm_wdata_q;
  logic                dm_we_q;
  logic                done_q;

  assign wr_cnt_d = wr_cnt_q + 1'b1;
  assign rd_cnt_d = rd_cnt_q + 1'b1;

  // NOTE: every register in this block is updated with non-blocking
  // assignments so all of them see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b1;
      proc_rst_q  <= 1'b1;
      mem_sel_q   <= 1'b1;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      // dm_we is a single-cycle strobe; only an accepted input byte raises it.
      dm_we_q <= 1'b0;

      case (state_q)
        S_LOAD: begin
          if (in_ready_q) begin
            if (in_valid) begin
              dm_we_q    <= 1'b1;
              dm_addr_q  <= wr_cnt_q;
              dm_wdata_q <= in_data;
              wr_cnt_q   <= wr_cnt_d;
              if (wr_cnt_q == IN_LAST) begin
                in_ready_q <= 1'b0;
              end
            end
          end else begin
            // in_ready low inside LOAD means the final write is on the DM
            // port this cycle; hand DM to the processor once it lands.
            state_q    <= S_RUN;
            proc_rst_q <= 1'b0;
            mem_sel_q  <= 1'b0;
          end
        end

        S_RUN: begin
          if (proc_done) begin
            state_q    <= S_RD_ADDR;
            proc_rst_q <= 1'b1;
            mem_sel_q  <= 1'b1;
            dm_addr_q  <= OUT_BASE_A + rd_cnt_q;
          end
        end

        // The read address is already on dm_addr during this state, so the
        // synchronous DM returns the byte during RD_WAIT.
        S_RD_ADDR: begin
          state_q <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          out_data_q  <= dm_rdata;
          out_valid_q <= 1'b1;
          state_q     <= S_RD_OUT;
        end

        S_RD_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            rd_cnt_q    <= rd_cnt_d;
            if (rd_cnt_q == OUT_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_RD_ADDR;
              dm_addr_q <= OUT_BASE_A + rd_cnt_d;
            end
          end
        end

        S_DONE: begin
          state_q <= S_DONE;
        end

        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign proc_rst  = proc_rst_q;
  assign mem_sel   = mem_sel_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dm_we     = dm_we_q;
  assign done      = done_q;

endmodule
